mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the data port of ram_dp between the CPU load/store path and a host
//  loader/DMA port (test-image load, signature readback) at run time.
//  Sits between cpu and ram_dp; the instruction port is untouched.
//  - CPU gets single-beat accesses.
//  - Host gets locked bursts of up to BURST_MAX beats with auto-increment.
// PARAMETERS
//  XLEN       32  data width; RAM word = XLEN bits
//  AW         31  halfword address width (byte address [XLEN-1:1])
//  BURST_MAX  16  max host burst length in beats (power of 2)
//  MAX_WAIT   8   starvation threshold, cycles (used only with MEM_ARB_STARVE_EN)
// PORTS
//  clock       in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high reset
//  cpu_req     in   1          CPU load or store request
//  cpu_we      in   1          1 = store
//  cpu_addr    in   AW         halfword address
//  cpu_wdata   in   XLEN       store data
//  cpu_gnt     out  1          beat accepted this cycle; CPU stalls while 0
//  cpu_rvalid  out  1          load data valid (1 cycle after granted read)
//  host_req    in   1          host burst request
//  host_we     in   1          1 = write burst
//  host_addr   in   AW         burst start address (halfword)
//  host_len    in   log2(BURST_MAX)+1  beats; 0 treated as 1, >BURST_MAX clamped
//  host_wdata  in   XLEN       write data, consumed on each host_gnt beat
//  host_gnt    out  1          one beat accepted this cycle
//  host_rvalid out  1          read data valid (1 cycle after granted read beat)
//  host_done   out  1          1-cycle pulse with the last granted beat
//  rdata       out  XLEN       registered RAM read data, shared by both requesters
//  ram_we      out  1          to ram_dp.write_en
//  ram_addr    out  AW         to ram_dp.daddr
//  ram_wdata   out  XLEN       to ram_dp.data_i
//  ram_rdata   in   XLEN       from ram_dp.data_o, synchronous, 1-cycle latency
// BEHAVIOUR
//  Reset values:
//  - all outputs 0; state IDLE; beat counter, address register and wait counter 0.
//  FSM: IDLE, HOST_BURST.
//  IDLE, host_req=0:
//  - cpu_gnt = cpu_req, combinational, same cycle.
//  - RAM port driven from cpu_*; ram_we = cpu_req & cpu_we.
//  IDLE, host_req=1 and cpu_req=0 (or host wins priority):
//  - latch host_addr and host_len; first beat granted in the same cycle.
//  - go to HOST_BURST if len > 1, else stay IDLE.
//  IDLE, both requesting:
//  - CPU wins (fixed priority) unless the starvation guard fires.
//  HOST_BURST:
//  - host_gnt = 1 every cycle; cpu_gnt = 0.
//  - address += XLEN/16 per beat; wraps modulo 2^AW.
//  - host_req is ignored after the first beat; the burst always completes.
//  - host_done pulses on the final beat, then return to IDLE.
//  - A CPU request pending at the end of a burst is granted in the first
//    IDLE cycle, before any new host burst.
//  Read data:
//  - cpu_rvalid / host_rvalid are registered copies of (gnt & ~we) per
//    requester; rdata = ram_rdata in that cycle.
//  - Back-to-back reads give back-to-back rvalid pulses.
//  Reset mid-burst:
//  - burst aborted, no further RAM writes, host_done not pulsed.
//  Invariants:
//  - cpu_gnt and host_gnt are never both 1.
//  - ram_we = 0 whenever neither grant is asserted.
// CONFIGURATION
//  MEM_ARB_STARVE_EN defined:
//  - A wait counter increments each cycle host_req=1 and host_gnt=0, and
//    clears on host_gnt.
//  - When the counter reaches MAX_WAIT, the host wins the next IDLE
//    arbitration over a pending CPU request.
//  MEM_ARB_STARVE_EN undefined:
//  - Strict CPU priority; the host may starve indefinitely; no counter logic.
// TESTING
//  1. CPU store addr=0x100 data=0xDEADBEEF, then load 0x100 -> ram_we 1 cycle;
//     cpu_rvalid 1 cycle after the load grant, rdata=0xDEADBEEF.
//  2. Host write burst addr=0x0 len=4 data 1..4 -> host_gnt 4 consecutive cycles,
//     ram_addr 0,2,4,6, host_done on beat 4; readback by a len=4 read returns 1..4.
//  3. CPU req arrives on cycle 2 of a len=8 host burst -> cpu_gnt=0 until the
//     burst ends; CPU granted on the first IDLE cycle after host_done.
//  4. cpu_req held high, host_req high -> without the macro, host_gnt stays 0 for
//     100 cycles; with MEM_ARB_STARVE_EN, host granted after exactly 8 wait cycles.
//  5. Reset asserted during beat 3 of a len=8 write burst -> outputs 0 immediately;
//     addresses beyond beat 2 unwritten; state IDLE on release.
//  6. host_len=0 -> single beat with host_done; host_addr=max, len=2 ->
//     second beat address wraps to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the ram_dp data port between the CPU load/store path
// (single-beat accesses) and a host loader/DMA port (locked bursts with
// address auto-increment).
// Optional feature macro: MEM_ARB_STARVE_EN. When it is defined, a wait
// counter lets a starved host win one IDLE arbitration over the CPU.
//
// Handshake: a *_req input is the requester's valid and the matching *_gnt
// output is ready. A beat transfers in any cycle where gnt is 1. The first
// host beat also needs host_req=1. Later beats of a burst are granted
// unconditionally and host_req is not looked at. host_wdata is consumed on
// each granted host beat.
module mem_arbiter #(
    parameter int XLEN      = 32,
    parameter int AW        = 31,
    parameter int BURST_MAX = 16,
    parameter int MAX_WAIT  = 8,
    parameter int LW        = $clog2(BURST_MAX) + 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_cpu_req,
    input  logic            i_cpu_we,
    input  logic [AW-1:0]   i_cpu_addr,
    input  logic [XLEN-1:0] i_cpu_wdata,
    output logic            o_cpu_gnt,
    output logic            o_cpu_rvalid,
    input  logic            i_host_req,
    input  logic            i_host_we,
    input  logic [AW-1:0]   i_host_addr,
    input  logic [LW-1:0]   i_host_len,
    input  logic [XLEN-1:0] i_host_wdata,
    output logic            o_host_gnt,
    output logic            o_host_rvalid,
    output logic            o_host_done,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_ram_we,
    output logic [AW-1:0]   o_ram_addr,
    output logic [XLEN-1:0] o_ram_wdata,
    input  logic [XLEN-1:0] i_ram_rdata,
    output logic            o_dbg_state
);

    typedef enum logic {IDLE = 1'b0, HOST_BURST = 1'b1} state_t;

    // One beat moves one RAM word, which is XLEN/16 halfwords.
    localparam logic [AW-1:0] STEP = AW'(XLEN / 16);

    state_t          r_state;
    logic [LW-1:0]   r_cnt;      // beats still to go, including the current one
    logic [AW-1:0]   r_addr;     // address of the next burst beat
    logic            r_we;       // direction of the burst in progress
    logic            r_cpu_rvalid;
    logic            r_host_rvalid;

    logic [LW-1:0]   w_len;
    logic            w_idle;
    logic            w_starve;
    logic            w_host_start;
    logic            w_cpu_gnt;
    logic            w_host_gnt;
    logic [AW-1:0]   w_beat_addr;
    logic            w_beat_we;
    logic            w_last;

    // Clamp the requested burst length: 0 means one beat, and the length never exceeds BURST_MAX.
    always_comb begin
        if (i_host_len == '0)
            w_len = LW'(1);
        else if (i_host_len > LW'(BURST_MAX))
            w_len = LW'(BURST_MAX);
        else
            w_len = i_host_len;
    end

`ifdef MEM_ARB_STARVE_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] r_wait;

    assign w_starve = (r_wait >= WW'(MAX_WAIT));

    // Count cycles where the host waits ungranted; saturate at MAX_WAIT.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_wait <= '0;
        else if (w_host_gnt)
            r_wait <= '0;
        else if (i_host_req && (r_wait < WW'(MAX_WAIT)))
            r_wait <= r_wait + WW'(1);
    end
`else
    // Strict CPU priority: the guard can never fire.
    assign w_starve = (MAX_WAIT < 0);
`endif

    assign w_idle       = (r_state == IDLE);
    assign w_host_start = w_idle & i_host_req & (~i_cpu_req | w_starve);
    assign w_cpu_gnt    = w_idle & i_cpu_req & ~w_host_start;
    assign w_host_gnt   = w_host_start | ~w_idle;
    assign w_beat_addr  = w_idle ? i_host_addr : r_addr;
    assign w_beat_we    = w_idle ? i_host_we : r_we;
    assign w_last       = w_idle ? (w_len == LW'(1)) : (r_cnt == LW'(1));

    // Grants and the RAM request are combinational. They are forced to 0 while reset is held.
    always_comb begin
        o_cpu_gnt   = ~i_reset & w_cpu_gnt;
        o_host_gnt  = ~i_reset & w_host_gnt;
        o_host_done = ~i_reset & w_host_gnt & w_last;
        o_ram_we    = ~i_reset & ((w_cpu_gnt & i_cpu_we) | (w_host_gnt & w_beat_we));
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (!i_reset) begin
            o_ram_addr  = w_host_gnt ? w_beat_addr : i_cpu_addr;
            o_ram_wdata = w_host_gnt ? i_host_wdata : i_cpu_wdata;
        end
    end

    assign o_cpu_rvalid  = r_cpu_rvalid;
    assign o_host_rvalid = r_host_rvalid;
    assign o_rdata       = (r_cpu_rvalid | r_host_rvalid) ? i_ram_rdata : '0;
    assign o_dbg_state   = r_state;

    // Arbitration FSM: burst bookkeeping plus the read-valid pipeline stage.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_cpu_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid  <= w_cpu_gnt & ~i_cpu_we;
            r_host_rvalid <= w_host_gnt & ~w_beat_we;
            if (w_host_gnt)
                r_addr <= w_beat_addr + STEP;
            case (r_state)
                IDLE: begin
                    if (w_host_start) begin
                        r_we  <= i_host_we;
                        r_cnt <= w_len - LW'(1);
                        if (w_len > LW'(1))
                            r_state <= HOST_BURST;
                    end
                end
                HOST_BURST: begin
                    r_cnt <= r_cnt - LW'(1);
                    if (r_cnt == LW'(1))
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
